// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: command kinds, ALU opcodes
// and the sequencer FSM encoding.
package alu_pkg;

    localparam int W = 6;

    typedef enum logic [1:0] {
        CMD_LOAD  = 2'b00,
        CMD_EXEC  = 2'b01,
        CMD_CLEAR = 2'b10,
        CMD_TEST  = 2'b11
    } cmd_kind_e;

    localparam logic [3:0] ALU_OP_ADD = 4'b0001;
    localparam logic [3:0] ALU_OP_SUB = 4'b0010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } seq_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO holding packed {kind, op, data} commands.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module cmd_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] L_DEPTH = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_count == L_DEPTH);
    assign o_empty   = (r_count == '0);
    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of a combinational 6-bit ALU: buffers commands,
// issues operands from the accumulator and returns one result per command.
module alu_cmd_sequencer #(
    parameter int W          = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_kind,
    input  logic [3:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic [W-1:0] alu_x,
    output logic [W-1:0] alu_y,
    output logic [3:0]   alu_op,
    input  logic [W-1:0] alu_z,
    input  logic         alu_iof,
    input  logic         alu_baf,
    input  logic         alu_zf,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_iof,
    output logic         res_baf,
    output logic         res_zf,
    output logic         sticky_ovf
);

    import alu_pkg::*;

    localparam int FW = 2 + 4 + W;

    logic [FW-1:0] w_fifo_rdata;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    cmd_kind_e     w_kind;
    logic [3:0]    w_op;
    logic [W-1:0]  w_data;

    seq_state_e    r_state;
    seq_state_e    w_state_nxt;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_alu_x;
    logic [W-1:0]  r_alu_y;
    logic [3:0]    r_alu_op;
    logic          r_iof;
    logic          r_baf;
    logic          r_zf;
    logic          r_sticky;
    logic          r_res_valid;
    logic          r_is_exec;

    cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (cmd_valid),
        .i_wr_data ({cmd_kind, cmd_op, cmd_data}),
        .i_pop     (w_pop),
        .o_rd_data (w_fifo_rdata),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign w_kind = cmd_kind_e'(w_fifo_rdata[FW-1 -: 2]);
    assign w_op   = w_fifo_rdata[W+3 -: 4];
    assign w_data = w_fifo_rdata[W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_kind == CMD_EXEC || w_kind == CMD_TEST) w_state_nxt = ST_EXEC;
                    else                                          w_state_nxt = ST_RESP;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (res_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_alu_x     <= '0;
            r_alu_y     <= '0;
            r_alu_op    <= '0;
            r_iof       <= 1'b0;
            r_baf       <= 1'b0;
            r_zf        <= 1'b0;
            r_sticky    <= 1'b0;
            r_res_valid <= 1'b0;
            r_is_exec   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        case (w_kind)
                            CMD_LOAD: begin
                                r_acc       <= w_data;
                                {r_iof, r_baf, r_zf} <= 3'b000;
                                r_res_valid <= 1'b1;
                            end
                            CMD_CLEAR: begin
                                r_acc       <= '0;
                                {r_iof, r_baf, r_zf} <= 3'b000;
                                r_sticky    <= 1'b0;
                                r_res_valid <= 1'b1;
                            end
                            default: begin
                                r_alu_x   <= r_acc;
                                r_alu_y   <= w_data;
                                r_alu_op  <= w_op;
                                r_is_exec <= (w_kind == CMD_EXEC);
                            end
                        endcase
                    end
                end
                // ALU inputs have been stable for a full cycle; capture its outputs.
                ST_EXEC: begin
                    r_iof       <= alu_iof;
                    r_baf       <= alu_baf;
                    r_zf        <= alu_zf;
                    r_sticky    <= r_sticky | alu_iof;
                    if (r_is_exec) r_acc <= alu_z;
                    r_res_valid <= 1'b1;
                end
                ST_RESP: if (res_ready) r_res_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign cmd_ready  = !w_full;
    assign alu_x      = r_alu_x;
    assign alu_y      = r_alu_y;
    assign alu_op     = r_alu_op;
    assign res_valid  = r_res_valid;
    assign res_data   = r_acc;
    assign res_iof    = r_iof;
    assign res_baf    = r_baf;
    assign res_zf     = r_zf;
    assign sticky_ovf = r_sticky;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed scenarios plus a random
// command stream checked against an in-order accumulator model.
module tb_alu_cmd_sequencer;

    localparam int W  = 6;
    localparam int FD = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_kind = 2'b00;
    logic [3:0]   cmd_op = 4'b0000;
    logic [W-1:0] cmd_data = '0;
    logic [W-1:0] alu_x, alu_y, alu_z;
    logic [3:0]   alu_op;
    logic         alu_iof, alu_baf, alu_zf;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic         res_iof, res_baf, res_zf, sticky_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] m_acc = '0;
    logic         m_sticky = 1'b0;
    logic [W+3:0] exp_q[$];
    logic [W+3:0] got_q[$];

    alu_cmd_sequencer #(.W(W), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_z(alu_z), .alu_iof(alu_iof), .alu_baf(alu_baf), .alu_zf(alu_zf),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_iof(res_iof), .res_baf(res_baf), .res_zf(res_zf),
        .sticky_ovf(sticky_ovf)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {z, iof (carry/borrow), baf (signed overflow), zf}.
    function automatic logic [W+2:0] alu_f(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [3:0] op);
        logic [W:0]   t;
        logic [W-1:0] z;
        logic         iof;
        logic         baf;
        iof = 1'b0;
        baf = 1'b0;
        case (op)
            4'b0001: begin
                t   = {1'b0, x} + {1'b0, y};
                iof = t[W];
                baf = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
            end
            4'b0010: begin
                t   = {1'b0, x} - {1'b0, y};
                iof = t[W];
                baf = (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]);
            end
            4'b0011: t = {1'b0, x & y};
            4'b0100: t = {1'b0, x | y};
            4'b0101: t = {1'b0, x ^ y};
            default: t = {1'b0, y};
        endcase
        z = t[W-1:0];
        return {z, iof, baf, (z == '0)};
    endfunction

    always_comb {alu_z, alu_iof, alu_baf, alu_zf} = alu_f(alu_x, alu_y, alu_op);

    // Commands complete in acceptance order, so the expected result can be
    // computed the moment a command is accepted.
    task automatic model_cmd(input logic [1:0] k, input logic [3:0] op, input logic [W-1:0] d);
        logic [W+2:0] r;
        case (k)
            2'b00: begin
                m_acc = d;
                exp_q.push_back({m_acc, 3'b000, m_sticky});
            end
            2'b10: begin
                m_acc    = '0;
                m_sticky = 1'b0;
                exp_q.push_back({m_acc, 3'b000, m_sticky});
            end
            default: begin
                r        = alu_f(m_acc, d, op);
                m_sticky = m_sticky | r[2];
                if (k == 2'b01) m_acc = r[W+2:3];
                exp_q.push_back({m_acc, r[2:0], m_sticky});
            end
        endcase
    endtask

    task automatic tick();
        if (res_valid && res_ready)
            got_q.push_back({res_data, res_iof, res_baf, res_zf, sticky_ovf});
        if (cmd_valid && cmd_ready && rst_n)
            model_cmd(cmd_kind, cmd_op, cmd_data);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] k, input logic [3:0] op, input logic [W-1:0] d);
        bit ok;
        ok        = 1'b0;
        cmd_kind  = k;
        cmd_op    = op;
        cmd_data  = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL send_timeout: cmd_ready stayed %b, required 1", cmd_ready);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < 200 && got_q.size() < n; i++) tick();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({cmd_ready, res_valid} !== 2'b10)
            $display("FAIL reset_hs: got %b, required 10", {cmd_ready, res_valid});
        else n_pass++;
        n_checks++;
        if ({alu_x, alu_y, alu_op} !== '0)
            $display("FAIL reset_alu: got %h, required 0", {alu_x, alu_y, alu_op});
        else n_pass++;
        n_checks++;
        if ({res_data, res_iof, res_baf, res_zf, sticky_ovf} !== '0)
            $display("FAIL reset_res: got %h, required 0", {res_data, res_iof, res_baf, res_zf, sticky_ovf});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_exec();
        logic [W+3:0] want [2];
        want[0] = {6'd5, 4'b0000};
        want[1] = {6'd8, 4'b0000};
        res_ready = 1'b1;
        send(2'b00, 4'b0000, 6'd5);
        n_checks++;
        if (res_valid !== 1'b0) $display("FAIL load_lat0: res_valid %b, required 0", res_valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({res_valid, res_data} !== {1'b1, 6'd5})
            $display("FAIL load_lat1: got %h, required %h", {res_valid, res_data}, {1'b1, 6'd5});
        else n_pass++;
        tick();
        send(2'b01, 4'b0001, 6'd3);
        n_checks++;
        if (res_valid !== 1'b0) $display("FAIL exec_lat0: res_valid %b, required 0", res_valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({res_valid, alu_x, alu_y, alu_op} !== {1'b0, 6'd5, 6'd3, 4'b0001})
            $display("FAIL exec_issue: got %h, required %h", {res_valid, alu_x, alu_y, alu_op},
                     {1'b0, 6'd5, 6'd3, 4'b0001});
        else n_pass++;
        tick();
        n_checks++;
        if ({res_valid, res_data, res_zf} !== {1'b1, 6'd8, 1'b0})
            $display("FAIL exec_lat2: got %h, required %h", {res_valid, res_data, res_zf}, {1'b1, 6'd8, 1'b0});
        else n_pass++;
        drain(2);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= got_q.size()) $display("FAIL load_exec_missing[%0d]: none, required %h", i, want[i]);
            else if (got_q[i] !== want[i])
                $display("FAIL load_exec_res[%0d]: got %h, required %h", i, got_q[i], want[i]);
            else n_pass++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_overflow_clear();
        logic [W+3:0] want [3];
        want[0] = {6'd63, 4'b0000};
        want[1] = {6'd0,  4'b1011};
        want[2] = {6'd0,  4'b0000};
        res_ready = 1'b1;
        send(2'b00, 4'b0000, 6'd63);
        send(2'b01, 4'b0001, 6'd1);
        drain(2);
        n_checks++;
        if (sticky_ovf !== 1'b1) $display("FAIL sticky_set: got %b, required 1", sticky_ovf);
        else n_pass++;
        send(2'b10, 4'b0000, 6'd17);
        drain(3);
        n_checks++;
        if (sticky_ovf !== 1'b0) $display("FAIL sticky_clear: got %b, required 0", sticky_ovf);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= got_q.size()) $display("FAIL ovf_missing[%0d]: none, required %h", i, want[i]);
            else if (got_q[i] !== want[i])
                $display("FAIL ovf_res[%0d]: got %h, required %h", i, got_q[i], want[i]);
            else n_pass++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_compare();
        logic [W+3:0] want [2];
        want[0] = {6'd9, 4'b0000};
        want[1] = {6'd9, 4'b0010};
        res_ready = 1'b1;
        send(2'b00, 4'b0000, 6'd9);
        send(2'b11, 4'b0010, 6'd9);
        drain(2);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= got_q.size()) $display("FAIL test_missing[%0d]: none, required %h", i, want[i]);
            else if (got_q[i] !== want[i])
                $display("FAIL test_res[%0d]: got %h, required %h", i, got_q[i], want[i]);
            else n_pass++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [W+3:0] want [3];
        want[0] = {6'd1, 4'b0000};
        want[1] = {6'd3, 4'b0000};
        want[2] = {6'd6, 4'b0000};
        res_ready = 1'b0;
        send(2'b00, 4'b0000, 6'd1);
        send(2'b01, 4'b0001, 6'd2);
        send(2'b01, 4'b0001, 6'd3);
        n_checks++;
        if ({cmd_ready, res_valid, res_data} !== {1'b0, 1'b1, 6'd1})
            $display("FAIL bp_full: got %h, required %h", {cmd_ready, res_valid, res_data}, {1'b0, 1'b1, 6'd1});
        else n_pass++;
        repeat (4) tick();
        n_checks++;
        if ({cmd_ready, res_valid, res_data, res_iof, res_baf, res_zf} !== {1'b0, 1'b1, 6'd1, 3'b000})
            $display("FAIL bp_hold: got %h, required %h",
                     {cmd_ready, res_valid, res_data, res_iof, res_baf, res_zf}, {1'b0, 1'b1, 6'd1, 3'b000});
        else n_pass++;
        res_ready = 1'b1;
        drain(3);
        repeat (3) tick();
        n_checks++;
        if (got_q.size() != 3) $display("FAIL bp_count: got %0d, required 3", got_q.size());
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= got_q.size()) $display("FAIL bp_missing[%0d]: none, required %h", i, want[i]);
            else if (got_q[i] !== want[i])
                $display("FAIL bp_res[%0d]: got %h, required %h", i, got_q[i], want[i]);
            else n_pass++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midop();
        res_ready = 1'b0;
        send(2'b00, 4'b0000, 6'd63);
        send(2'b01, 4'b0001, 6'd1);
        cmd_kind  = 2'b01;
        cmd_op    = 4'b0001;
        cmd_data  = 6'd1;
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({cmd_ready, res_valid} !== 2'b10)
            $display("FAIL rst_mid_hs: got %b, required 10", {cmd_ready, res_valid});
        else n_pass++;
        n_checks++;
        if ({alu_x, alu_y, alu_op, res_data, res_iof, res_baf, res_zf, sticky_ovf} !== '0)
            $display("FAIL rst_mid_out: got %h, required 0",
                     {alu_x, alu_y, alu_op, res_data, res_iof, res_baf, res_zf, sticky_ovf});
        else n_pass++;
        got_q.delete();
        exp_q.delete();
        m_acc    = '0;
        m_sticky = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (10) tick();
        n_checks++;
        if (got_q.size() != 0 || res_valid !== 1'b0)
            $display("FAIL rst_mid_stale: got %0d results, required 0", got_q.size());
        else n_pass++;
        got_q.delete();
    endtask

    task automatic test_random();
        int sent;
        int n;
        logic [3:0] ops [6];
        ops[0] = 4'b0001; ops[1] = 4'b0010; ops[2] = 4'b0011;
        ops[3] = 4'b0100; ops[4] = 4'b0101; ops[5] = 4'b1111;
        sent = 0;
        for (int c = 0; c < 3000 && sent < 40; c++) begin
            bit acc_now;
            res_ready = ($urandom_range(0, 3) != 0);
            if (!cmd_valid && $urandom_range(0, 1) == 1) begin
                cmd_kind  = ($urandom_range(0, 9) < 6) ? 2'($urandom_range(1, 1) + 2 * $urandom_range(0, 1))
                                                       : 2'($urandom_range(0, 1) * 2);
                cmd_op    = ops[$urandom_range(0, 5)];
                cmd_data  = W'($urandom);
                cmd_valid = 1'b1;
            end
            acc_now = cmd_valid && cmd_ready;
            tick();
            if (acc_now) begin
                cmd_valid = 1'b0;
                sent++;
            end
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        drain(exp_q.size());
        n_checks++;
        if (got_q.size() != exp_q.size() || sent != 40)
            $display("FAIL rand_count: got %0d results of %0d sent, required %0d of 40",
                     got_q.size(), sent, exp_q.size());
        else n_pass++;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL rand_res[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_load_exec();
        test_overflow_clear();
        test_compare();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

endmodule
